// File: rtl/noc_pkg.sv
// Shared router definitions: port count, port indices and arbiter state encoding.
package noc_pkg;

   localparam int unsigned NPORTS = 5;

   localparam int unsigned PORT_L = 0;
   localparam int unsigned PORT_N = 1;
   localparam int unsigned PORT_E = 2;
   localparam int unsigned PORT_S = 3;
   localparam int unsigned PORT_W = 4;

   typedef enum logic {
      IDLE,
      LOCKED
   } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational circular priority encoder: first set req bit at or after ptr, scanning upward.
module rr_priority_pick #(
   parameter int unsigned N  = 5,
   parameter int unsigned PW = 3
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  winner,
   output logic          any
);

   // Two linear passes replace a modulo scan: first the bits at or above ptr, then the wrap.
   always_comb begin
      winner = '0;
      any    = 1'b0;
      for (int unsigned j = 0; j < N; j++) begin
         if (!any && req[j] && (j >= 32'(ptr))) begin
            winner[j] = 1'b1;
            any       = 1'b1;
         end
      end
      for (int unsigned j = 0; j < N; j++) begin
         if (!any && req[j]) begin
            winner[j] = 1'b1;
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/output_port_arbiter.sv
// Round-robin, packet-locking output-port arbiter with downstream credit tracking.
module output_port_arbiter #(
   parameter int unsigned NPORTS    = noc_pkg::NPORTS,
   parameter int unsigned BUF_DEPTH = 4,
   parameter int unsigned CNT_W     = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NPORTS-1:0] req,
   input  logic [NPORTS-1:0] flit_valid,
   input  logic [NPORTS-1:0] flit_tail,
   input  logic              credit_in,
   output logic [NPORTS-1:0] grant,
   output logic [NPORTS-1:0] select,
   output logic              flit_fire,
   output logic              credit_err
);
   import noc_pkg::*;

   localparam int unsigned PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

   arb_state_t        state_q, state_d;
   logic [NPORTS-1:0] grant_q, grant_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [CNT_W-1:0]  credits_q, credits_d;
   logic              err_q, err_d;
   logic [NPORTS-1:0] winner;
   logic              any;
   logic [PW-1:0]     owner_idx;
   logic              have_credit;
   logic              tail_fire;

   rr_priority_pick #(
      .N  (NPORTS),
      .PW (PW)
   ) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .winner (winner),
      .any    (any)
   );

   always_comb begin
      owner_idx = '0;
      for (int unsigned j = 0; j < NPORTS; j++) begin
         if (grant_q[j]) owner_idx = PW'(j);
      end
   end

   assign have_credit = (credits_q != '0);
   assign flit_fire   = (state_q == LOCKED) && |(flit_valid & grant_q) && have_credit;
   assign tail_fire   = flit_fire && |(flit_tail & grant_q);
   assign grant       = grant_q;
   assign select      = grant_q;
   assign credit_err  = err_q;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (any && have_credit) begin
               grant_d = winner;
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (tail_fire) begin
               grant_d = '0;
               ptr_d   = (owner_idx == PW'(NPORTS - 1)) ? '0 : owner_idx + 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // A credit returned while full saturates and latches the error until reset.
   always_comb begin
      credits_d = credits_q;
      err_d     = err_q;
      if (flit_fire && !credit_in) begin
         credits_d = credits_q - 1'b1;
      end else if (credit_in && !flit_fire) begin
         if (credits_q == FULL) err_d = 1'b1;
         else                   credits_d = credits_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         ptr_q     <= '0;
         credits_q <= FULL;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         credits_q <= credits_d;
         err_q     <= err_d;
      end
   end

endmodule
